// File: rtl/mips_pipe_pkg.sv
// Shared encodings for the 5-stage MIPS pipeline: PC source, RegDst, special
// registers and the hazard unit FSM state type.
package mips_pipe_pkg;

    localparam logic [2:0] PCSRC_PC4 = 3'b000;
    localparam logic [2:0] PCSRC_BR  = 3'b001;
    localparam logic [2:0] PCSRC_J   = 3'b010;
    localparam logic [2:0] PCSRC_JR  = 3'b011;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } hz_state_e;

    function automatic logic is_jump(input logic [2:0] pc_src);
        is_jump = (pc_src == PCSRC_J) || (pc_src == PCSRC_JR);
    endfunction

endpackage

// File: rtl/hazard_src_match.sv
// Destination-versus-source register compare; register 0 and an invalid
// producer never match.
module hazard_src_match
    import mips_pipe_pkg::*;
(
    input  logic       valid,
    input  logic [4:0] dest,
    input  logic [4:0] src,
    output logic       match
);

    // Qualified equality compare
    always_comb begin
        match = valid && (dest != REG_ZERO) && (dest == src);
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use / jr-after-load stall and branch/jump flush controller.
// Optional performance counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_stall_unit
    import mips_pipe_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int STALL_CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       RS_IF_ID,
    input  logic [4:0]       RT_IF_ID,
    input  logic             UsesRt_IF_ID,
    input  logic [2:0]       PCSrc,
    input  logic             MemRead_ID_EX,
    input  logic             RegWrite_ID_EX,
    input  logic [4:0]       AddrC_ID_EX,
    input  logic             MemRead_EX_MEM,
    input  logic [4:0]       AddrC_EX_MEM,
    input  logic             BranchTaken_EX,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             ID_EX_Bubble,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             StallActive,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCount
);

    localparam logic [STALL_CNT_W-1:0] CNT_ZERO = STALL_CNT_W'(0);
    localparam logic [STALL_CNT_W-1:0] CNT_ONE  = STALL_CNT_W'(1);

    hz_state_e              state_r;
    hz_state_e              state_nxt_s;
    logic [STALL_CNT_W-1:0] cnt_r;
    logic [STALL_CNT_W-1:0] cnt_nxt_s;
    logic                   stall_active_r;
    logic                   is_jr_s;
    logic                   lu_rs_s;
    logic                   lu_rt_s;
    logic                   jr_ex_s;
    logic                   jr_mem_s;
    logic [1:0]             need_s;
    logic                   unused_regwrite_s;

    // A non-load producer in EX is always covered by forwarding, so RegWrite never stalls.
    assign unused_regwrite_s = RegWrite_ID_EX;
    assign is_jr_s           = (PCSrc == PCSRC_JR);

    hazard_src_match u_lu_rs (
        .valid (MemRead_ID_EX),
        .dest  (AddrC_ID_EX),
        .src   (RS_IF_ID),
        .match (lu_rs_s)
    );

    hazard_src_match u_lu_rt (
        .valid (MemRead_ID_EX && UsesRt_IF_ID),
        .dest  (AddrC_ID_EX),
        .src   (RT_IF_ID),
        .match (lu_rt_s)
    );

    hazard_src_match u_jr_ex (
        .valid (MemRead_ID_EX && is_jr_s),
        .dest  (AddrC_ID_EX),
        .src   (RS_IF_ID),
        .match (jr_ex_s)
    );

    hazard_src_match u_jr_mem (
        .valid (MemRead_EX_MEM && is_jr_s),
        .dest  (AddrC_EX_MEM),
        .src   (RS_IF_ID),
        .match (jr_mem_s)
    );

    // Stall length required by the instruction in ID (max of matching rules)
    always_comb begin
        need_s = 2'd0;
        if (jr_ex_s) begin
            need_s = 2'd2;
        end else if (lu_rs_s || lu_rt_s || jr_mem_s) begin
            need_s = 2'd1;
        end else begin
            need_s = 2'd0;
        end
    end

    // Next-state and pipeline control; a taken branch overrides any stall
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Bubble = 1'b0;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        if (BranchTaken_EX) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
            state_nxt_s = ST_RUN;
            cnt_nxt_s   = CNT_ZERO;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (need_s != 2'd0) begin
                        PCWrite      = 1'b0;
                        IF_ID_Write  = 1'b0;
                        ID_EX_Bubble = 1'b1;
                        if (need_s == 2'd2) begin
                            state_nxt_s = ST_STALL;
                            cnt_nxt_s   = CNT_ONE;
                        end else begin
                            state_nxt_s = ST_RUN;
                            cnt_nxt_s   = CNT_ZERO;
                        end
                    end else begin
                        state_nxt_s = ST_RUN;
                        cnt_nxt_s   = CNT_ZERO;
                        if (is_jump(PCSrc)) begin
                            IF_ID_Flush = 1'b1;
                        end else begin
                            IF_ID_Flush = 1'b0;
                        end
                    end
                end
                ST_STALL: begin
                    // Freeze is held blindly; the compare would be stale mid-stall
                    PCWrite      = 1'b0;
                    IF_ID_Write  = 1'b0;
                    ID_EX_Bubble = 1'b1;
                    if (cnt_r <= CNT_ONE) begin
                        state_nxt_s = ST_RUN;
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
                        state_nxt_s = ST_STALL;
                        cnt_nxt_s   = cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // FSM state, stall counter and registered stall indicator
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= ST_RUN;
            cnt_r          <= CNT_ZERO;
            stall_active_r <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            cnt_r          <= cnt_nxt_s;
            stall_active_r <= (state_nxt_s == ST_STALL);
        end
    end

    assign StallActive = stall_active_r;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles_r;
    logic [CNT_W-1:0] flush_count_r;

    // Free-running event counters, wrap naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles_r <= '0;
            flush_count_r  <= '0;
        end else begin
            if (!PCWrite) begin
                stall_cycles_r <= stall_cycles_r + CNT_W'(1);
            end else begin
                stall_cycles_r <= stall_cycles_r;
            end
            if (IF_ID_Flush || ID_EX_Flush) begin
                flush_count_r <= flush_count_r + CNT_W'(1);
            end else begin
                flush_count_r <= flush_count_r;
            end
        end
    end

    assign StallCycles = stall_cycles_r;
    assign FlushCount  = flush_count_r;
`else
    assign StallCycles = '0;
    assign FlushCount  = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit; outputs are packed as
// {PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, ID_EX_Flush, StallActive}.
module tb_hazard_stall_unit;

    localparam int CNT_W = 32;

    logic             clk;
    logic             reset;
    logic [4:0]       RS_IF_ID;
    logic [4:0]       RT_IF_ID;
    logic             UsesRt_IF_ID;
    logic [2:0]       PCSrc;
    logic             MemRead_ID_EX;
    logic             RegWrite_ID_EX;
    logic [4:0]       AddrC_ID_EX;
    logic             MemRead_EX_MEM;
    logic [4:0]       AddrC_EX_MEM;
    logic             BranchTaken_EX;
    logic             PCWrite;
    logic             IF_ID_Write;
    logic             ID_EX_Bubble;
    logic             IF_ID_Flush;
    logic             ID_EX_Flush;
    logic             StallActive;
    logic [CNT_W-1:0] StallCycles;
    logic [CNT_W-1:0] FlushCount;

    int passed;
    int total;

    hazard_stall_unit #(.CNT_W(CNT_W), .STALL_CNT_W(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .RS_IF_ID       (RS_IF_ID),
        .RT_IF_ID       (RT_IF_ID),
        .UsesRt_IF_ID   (UsesRt_IF_ID),
        .PCSrc          (PCSrc),
        .MemRead_ID_EX  (MemRead_ID_EX),
        .RegWrite_ID_EX (RegWrite_ID_EX),
        .AddrC_ID_EX    (AddrC_ID_EX),
        .MemRead_EX_MEM (MemRead_EX_MEM),
        .AddrC_EX_MEM   (AddrC_EX_MEM),
        .BranchTaken_EX (BranchTaken_EX),
        .PCWrite        (PCWrite),
        .IF_ID_Write    (IF_ID_Write),
        .ID_EX_Bubble   (ID_EX_Bubble),
        .IF_ID_Flush    (IF_ID_Flush),
        .ID_EX_Flush    (ID_EX_Flush),
        .StallActive    (StallActive),
        .StallCycles    (StallCycles),
        .FlushCount     (FlushCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_outs(input string tag, input logic [5:0] exp);
        logic [5:0] obs;
        obs = {PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, ID_EX_Flush, StallActive};
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus after the falling edge; outputs settle #1 later.
    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                         input logic [2:0] pc_src, input logic mr_ex, input logic rw_ex,
                         input logic [4:0] dst_ex, input logic mr_mem, input logic [4:0] dst_mem,
                         input logic br);
        @(negedge clk);
        RS_IF_ID       = rs;
        RT_IF_ID       = rt;
        UsesRt_IF_ID   = uses_rt;
        PCSrc          = pc_src;
        MemRead_ID_EX  = mr_ex;
        RegWrite_ID_EX = rw_ex;
        AddrC_ID_EX    = dst_ex;
        MemRead_EX_MEM = mr_mem;
        AddrC_EX_MEM   = dst_mem;
        BranchTaken_EX = br;
        #1;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset  = 1'b1;
        RS_IF_ID = 5'd0; RT_IF_ID = 5'd0; UsesRt_IF_ID = 1'b0; PCSrc = 3'b000;
        MemRead_ID_EX = 1'b0; RegWrite_ID_EX = 1'b0; AddrC_ID_EX = 5'd0;
        MemRead_EX_MEM = 1'b0; AddrC_EX_MEM = 5'd0; BranchTaken_EX = 1'b0;
        #2;
        chk_outs("reset_outs", 6'b110000);
        chk_cnt("reset_stall_cnt", StallCycles, 32'd0);
        chk_cnt("reset_flush_cnt", FlushCount, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        drive(5'd0, 5'd0, 1'b0, 3'b000, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        chk_outs("idle", 6'b110000);

        // lw $8 ; add $9,$8,$1
        drive(5'd8, 5'd1, 1'b1, 3'b000, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0);
        chk_outs("lu_rs_stall", 6'b001000);
        drive(5'd8, 5'd1, 1'b1, 3'b000, 1'b0, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0);
        chk_outs("lu_rs_release", 6'b110000);

        // lw $5 ; sw $5,0($2)  then same rt without rt use
        drive(5'd2, 5'd5, 1'b1, 3'b000, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0);
        chk_outs("lu_rt_stall", 6'b001000);
        drive(5'd2, 5'd5, 1'b0, 3'b000, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0);
        chk_outs("lu_rt_unused", 6'b110000);

        // lw $31 ; jr $31 -> two stall cycles then delay-slot flush
        drive(5'd31, 5'd0, 1'b0, 3'b011, 1'b1, 1'b1, 5'd31, 1'b0, 5'd0, 1'b0);
        chk_outs("jr2_cycle1", 6'b001000);
        drive(5'd31, 5'd0, 1'b0, 3'b011, 1'b0, 1'b0, 5'd0, 1'b1, 5'd31, 1'b0);
        chk_outs("jr2_cycle2", 6'b001001);
        drive(5'd31, 5'd0, 1'b0, 3'b011, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        chk_outs("jr2_after_flush", 6'b110100);

        // addi $31 ; jr $31 -> forwarded, flush only
        drive(5'd31, 5'd0, 1'b0, 3'b011, 1'b0, 1'b1, 5'd31, 1'b0, 5'd0, 1'b0);
        chk_outs("jr_alu_producer", 6'b110100);

        // lw $0 ; add $2,$0,$0
        drive(5'd0, 5'd0, 1'b1, 3'b000, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        chk_outs("zero_reg", 6'b110000);

        // lw $31 in MEM ; jr $31 -> one stall cycle
        drive(5'd31, 5'd0, 1'b0, 3'b011, 1'b0, 1'b1, 5'd4, 1'b1, 5'd31, 1'b0);
        chk_outs("jr1_stall", 6'b001000);
        drive(5'd31, 5'd0, 1'b0, 3'b011, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        chk_outs("jr1_after_flush", 6'b110100);

        // JR2 stall interrupted by a taken branch in its second cycle
        drive(5'd31, 5'd0, 1'b0, 3'b011, 1'b1, 1'b1, 5'd31, 1'b0, 5'd0, 1'b0);
        chk_outs("jr2_br_cycle1", 6'b001000);
        drive(5'd31, 5'd0, 1'b0, 3'b011, 1'b0, 1'b0, 5'd0, 1'b1, 5'd31, 1'b1);
        chk_outs("jr2_br_flush", 6'b110111);
        drive(5'd0, 5'd0, 1'b0, 3'b000, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        chk_outs("jr2_br_run", 6'b110000);

        // plain jump, jump with branch, branch beating a load-use stall
        drive(5'd0, 5'd0, 1'b0, 3'b010, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        chk_outs("j_flush", 6'b110100);
        drive(5'd0, 5'd0, 1'b0, 3'b010, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
        chk_outs("j_with_branch", 6'b110110);
        drive(5'd8, 5'd0, 1'b0, 3'b000, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b1);
        chk_outs("branch_over_lu", 6'b110110);
        drive(5'd0, 5'd0, 1'b0, 3'b001, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        chk_outs("beq_not_taken", 6'b110000);

        // reset in the middle of a JR2 stall
        drive(5'd31, 5'd0, 1'b0, 3'b011, 1'b1, 1'b1, 5'd31, 1'b0, 5'd0, 1'b0);
        chk_outs("rst_stall_c1", 6'b001000);
        drive(5'd31, 5'd0, 1'b0, 3'b011, 1'b0, 1'b0, 5'd0, 1'b1, 5'd31, 1'b0);
        chk_outs("rst_stall_c2", 6'b001001);
        @(negedge clk);
        reset = 1'b1;
        MemRead_EX_MEM = 1'b0; AddrC_EX_MEM = 5'd0; PCSrc = 3'b000; RS_IF_ID = 5'd0;
        #1;
        chk_outs("rst_mid_stall", 6'b110000);
        chk_cnt("rst_mid_stall_cnt", StallCycles, 32'd0);
        chk_cnt("rst_mid_flush_cnt", FlushCount, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(5'd0, 5'd0, 1'b0, 3'b000, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        chk_outs("post_reset_run", 6'b110000);

`ifndef HAZARD_PERF_CNT_EN
        chk_cnt("cnt_tied_stall", StallCycles, 32'd0);
        chk_cnt("cnt_tied_flush", FlushCount, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
